// File: rtl/mcs4_bus_sequencer.sv
// MCS-4 style bus phase sequencer: A1..An address phases, then M1, M2, X1, X2, X3.
// Owns the split data bus, CM strobes and SYNC; all outputs decode registered state only.
module mcs4_bus_sequencer #(
  parameter int DATA_W       = 4,
  parameter int ADDR_NIBBLES = 3,
  parameter int N_CMRAM      = 4,
  parameter int PHASE_CLKS   = 2,
  parameter logic [DATA_W-1:0] IO_OPR = DATA_W'(4'hE),
  localparam int CS_W  = (N_CMRAM > 1) ? $clog2(N_CMRAM) : 1,
  localparam int PH_W  = $clog2(ADDR_NIBBLES + 5),
  localparam int SUB_W = $clog2(PHASE_CLKS)
) (
  input  logic                           sysclk,
  input  logic                           poc_n,
  input  logic                           run,
  input  logic [DATA_W*ADDR_NIBBLES-1:0] addr_in,
  input  logic [CS_W-1:0]                cm_sel,
  input  logic [DATA_W-1:0]              data_in,
  output logic [DATA_W-1:0]              data_out,
  output logic                           data_dir,
  input  logic                           x2_wr,
  input  logic                           x2_rd,
  input  logic [DATA_W-1:0]              x_wdata,
  output logic [DATA_W-1:0]              opr,
  output logic [DATA_W-1:0]              opa,
  output logic                           instr_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid,
  output logic                           cmrom,
  output logic [N_CMRAM-1:0]             cmram,
  output logic                           sync_out,
  output logic [PH_W-1:0]                phase
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [PH_W-1:0]  P_LA     = PH_W'(ADDR_NIBBLES - 1);
  localparam logic [PH_W-1:0]  P_M1     = PH_W'(ADDR_NIBBLES);
  localparam logic [PH_W-1:0]  P_M2     = PH_W'(ADDR_NIBBLES + 1);
  localparam logic [PH_W-1:0]  P_X1     = PH_W'(ADDR_NIBBLES + 2);
  localparam logic [PH_W-1:0]  P_X2     = PH_W'(ADDR_NIBBLES + 3);
  localparam logic [PH_W-1:0]  P_X3     = PH_W'(ADDR_NIBBLES + 4);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_CLKS - 1);

  state_t                         state, state_nx;
  logic [PH_W-1:0]                ph_q, ph_nx;
  logic [SUB_W-1:0]               sub_q, sub_nx;
  logic                           load;
  logic [DATA_W*ADDR_NIBBLES-1:0] addr_q;
  logic [CS_W-1:0]                cm_q;
  logic                           wr_q, rd_q;
  logic [DATA_W-1:0]              wdata_q;
  logic                           active, last_clk;

  assign active   = (state == ACTIVE);
  assign last_clk = active && (sub_q == SUB_LAST);

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      state <= IDLE;
      ph_q  <= '0;
      sub_q <= '0;
    end else begin
      state <= state_nx;
      ph_q  <= ph_nx;
      sub_q <= sub_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph_q;
    sub_nx   = sub_q;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nx = ACTIVE;
          ph_nx    = '0;
          sub_nx   = '0;
          load     = 1'b1;
        end
      end
      ACTIVE: begin
        if (sub_q == SUB_LAST) begin
          sub_nx = '0;
          // run is only looked at on the final clock of X3
          if (ph_q == P_X3) begin
            ph_nx = '0;
            if (run) load = 1'b1;
            else     state_nx = IDLE;
          end else begin
            ph_nx = ph_q + 1'b1;
          end
        end else begin
          sub_nx = sub_q + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      addr_q  <= '0;
      cm_q    <= '0;
      opr     <= '0;
      opa     <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      rd_data <= '0;
    end else begin
      if (load) begin
        addr_q <= addr_in;
        cm_q   <= cm_sel;
      end
      if (last_clk && ph_q == P_M1) opr <= data_in;
      if (last_clk && ph_q == P_M2) opa <= data_in;
      if (last_clk && ph_q == P_X1) begin
        wr_q    <= x2_wr;
        rd_q    <= x2_rd;
        wdata_q <= x_wdata;
      end
      if (last_clk && ph_q == P_X2 && rd_q && !wr_q) rd_data <= data_in;
    end
  end

  logic              addr_ph, wr_ph, cm_on;
  logic [DATA_W-1:0] nib;

  always_comb begin
    addr_ph     = active && (ph_q < P_M1);
    wr_ph       = active && (ph_q == P_X2) && wr_q;
    nib         = DATA_W'(addr_q >> (DATA_W * int'(ph_q)));
    cm_on       = active && ((ph_q == P_LA) || ((ph_q == P_M2) && (opr == IO_OPR)));
    data_dir    = addr_ph || wr_ph;
    data_out    = addr_ph ? nib : (wr_ph ? wdata_q : '0);
    cmrom       = cm_on;
    cmram       = cm_on ? (N_CMRAM'(1) << cm_q) : '0;
    instr_valid = active && (ph_q == P_X1) && (sub_q == '0);
    rd_valid    = active && (ph_q == P_X3) && (sub_q == '0) && rd_q && !wr_q;
    sync_out    = active && (ph_q == P_X3);
    phase       = ph_q;
  end

endmodule

// File: tb/tb_mcs4_bus_sequencer.sv
// Directed bench for mcs4_bus_sequencer: default instance plus a 4-nibble, 3-clock, 8-bank instance.
module tb_mcs4_bus_sequencer;

  logic sysclk = 1'b0;
  logic poc_n  = 1'b1;
  always #5 sysclk = ~sysclk;

  logic        run = 1'b0, x2_wr = 1'b0, x2_rd = 1'b0;
  logic [11:0] addr_in = '0;
  logic [1:0]  cm_sel = '0;
  logic [3:0]  data_in = '0, x_wdata = '0;
  logic [3:0]  data_out, opr, opa, rd_data, cmram;
  logic        data_dir, instr_valid, rd_valid, cmrom, sync_out;
  logic [2:0]  phase;

  logic        run2 = 1'b0;
  logic [15:0] addr_in2 = '0;
  logic [2:0]  cm_sel2 = '0;
  logic [3:0]  data_out2, opr2, opa2, rd_data2;
  logic        data_dir2, instr_valid2, rd_valid2, cmrom2, sync_out2;
  logic [7:0]  cmram2;
  logic [3:0]  phase2;

  mcs4_bus_sequencer u_dut (
    .sysclk(sysclk), .poc_n(poc_n), .run(run), .addr_in(addr_in), .cm_sel(cm_sel),
    .data_in(data_in), .data_out(data_out), .data_dir(data_dir), .x2_wr(x2_wr),
    .x2_rd(x2_rd), .x_wdata(x_wdata), .opr(opr), .opa(opa), .instr_valid(instr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .cmrom(cmrom), .cmram(cmram),
    .sync_out(sync_out), .phase(phase)
  );

  mcs4_bus_sequencer #(.ADDR_NIBBLES(4), .PHASE_CLKS(3), .N_CMRAM(8)) u_dut2 (
    .sysclk(sysclk), .poc_n(poc_n), .run(run2), .addr_in(addr_in2), .cm_sel(cm_sel2),
    .data_in(4'h0), .data_out(data_out2), .data_dir(data_dir2), .x2_wr(1'b0),
    .x2_rd(1'b0), .x_wdata(4'h0), .opr(opr2), .opa(opa2), .instr_valid(instr_valid2),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .cmrom(cmrom2), .cmram(cmram2),
    .sync_out(sync_out2), .phase(phase2)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0] c_out[16], c_ram[16];
  logic       c_dir[16], c_rom[16], c_sync[16], c_iv[16], c_rv[16];
  logic [2:0] c_ph[16];
  logic [3:0] e_out, e_ram;
  logic       e_dir, e_rom;

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  // Runs one 16-clock instruction cycle starting at A1 clock 0, capturing outputs per clock.
  task automatic do_cycle(input logic [3:0] m1, input logic [3:0] m2, input logic [3:0] x2d,
                          input logic wr, input logic rd, input logic [3:0] wd,
                          input logic run_after, input int drop_at, input logic [11:0] addr_next);
    for (int c = 0; c < 16; c++) begin
      data_in = (c == 6 || c == 7) ? m1 : (c == 8 || c == 9) ? m2 : (c == 12 || c == 13) ? x2d : 4'h0;
      x2_wr   = (c == 10 || c == 11) ? wr : 1'b0;
      x2_rd   = (c == 10 || c == 11) ? rd : 1'b0;
      x_wdata = (c == 10 || c == 11) ? wd : 4'h0;
      if (c == drop_at) run = run_after;
      if (c == 1) addr_in = addr_next;
      c_out[c] = data_out; c_dir[c] = data_dir; c_rom[c] = cmrom; c_ram[c] = cmram;
      c_sync[c] = sync_out; c_iv[c] = instr_valid; c_rv[c] = rd_valid; c_ph[c] = phase;
      tick();
    end
    data_in = '0; x2_wr = 1'b0; x2_rd = 1'b0; x_wdata = '0;
  endtask

  task automatic test_reset;
    #2 poc_n = 1'b0;
    tick(); tick();
    checks++; if (data_dir !== 1'b0 || data_out !== 4'h0) begin errors++; $display("FAIL reset_bus: dir=%b out=%h expected 0/0", data_dir, data_out); end
    checks++; if (cmrom !== 1'b0 || cmram !== 4'h0 || sync_out !== 1'b0) begin errors++; $display("FAIL reset_strobes: rom=%b ram=%b sync=%b expected 0", cmrom, cmram, sync_out); end
    checks++; if (opr !== 4'h0 || opa !== 4'h0 || rd_data !== 4'h0) begin errors++; $display("FAIL reset_latches: opr=%h opa=%h rd=%h expected 0", opr, opa, rd_data); end
    checks++; if (instr_valid !== 1'b0 || rd_valid !== 1'b0 || phase !== 3'd0) begin errors++; $display("FAIL reset_misc: iv=%b rv=%b ph=%0d expected 0", instr_valid, rd_valid, phase); end
    checks++; if (data_dir2 !== 1'b0 || cmram2 !== 8'h0 || phase2 !== 4'd0) begin errors++; $display("FAIL reset_dut2: dir=%b ram=%h ph=%0d expected 0", data_dir2, cmram2, phase2); end
    @(negedge sysclk) poc_n = 1'b1;
    tick();
  endtask

  task automatic test_addr_phase;
    addr_in = 12'h5A3; cm_sel = 2'd2; run = 1'b1;
    tick();
    do_cycle(4'hD, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 12'h5A3);
    for (int c = 0; c < 16; c++) begin
      e_out = (c < 2) ? 4'h3 : (c < 4) ? 4'hA : (c < 6) ? 4'h5 : 4'h0;
      e_dir = (c < 6);
      e_rom = (c == 4 || c == 5);
      e_ram = e_rom ? 4'b0100 : 4'b0000;
      checks++; if (c_out[c] !== e_out || c_dir[c] !== e_dir) begin errors++; $display("FAIL addr_bus c%0d: out=%h dir=%b expected %h/%b", c, c_out[c], c_dir[c], e_out, e_dir); end
      checks++; if (c_rom[c] !== e_rom || c_ram[c] !== e_ram) begin errors++; $display("FAIL addr_cm c%0d: rom=%b ram=%b expected %b/%b", c, c_rom[c], c_ram[c], e_rom, e_ram); end
      checks++; if (c_sync[c] !== (c >= 14)) begin errors++; $display("FAIL addr_sync c%0d: sync=%b expected %b", c, c_sync[c], (c >= 14)); end
      checks++; if (c_iv[c] !== (c == 10) || c_rv[c] !== 1'b0) begin errors++; $display("FAIL addr_valid c%0d: iv=%b rv=%b expected %b/0", c, c_iv[c], c_rv[c], (c == 10)); end
      checks++; if (c_ph[c] !== 3'(c / 2)) begin errors++; $display("FAIL addr_phase c%0d: phase=%0d expected %0d", c, c_ph[c], c / 2); end
    end
    checks++; if (opr !== 4'hD || opa !== 4'h4) begin errors++; $display("FAIL addr_oprs: opr=%h opa=%h expected D/4", opr, opa); end
    checks++; if (phase !== 3'd0 || data_dir !== 1'b0 || sync_out !== 1'b0) begin errors++; $display("FAIL addr_idle: ph=%0d dir=%b sync=%b expected 0", phase, data_dir, sync_out); end
  endtask

  task automatic test_io_opr;
    addr_in = 12'h123; cm_sel = 2'd1; run = 1'b1;
    tick();
    do_cycle(4'hE, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 12'h123);
    for (int c = 0; c < 16; c++) begin
      e_rom = (c == 4 || c == 5 || c == 8 || c == 9);
      e_ram = e_rom ? 4'b0010 : 4'b0000;
      checks++; if (c_rom[c] !== e_rom || c_ram[c] !== e_ram) begin errors++; $display("FAIL io_cm c%0d: rom=%b ram=%b expected %b/%b", c, c_rom[c], c_ram[c], e_rom, e_ram); end
    end
    checks++; if (opr !== 4'hE || opa !== 4'h3) begin errors++; $display("FAIL io_oprs: opr=%h opa=%h expected E/3", opr, opa); end
  endtask

  task automatic test_x2;
    addr_in = 12'h000; cm_sel = 2'd0; run = 1'b1;
    tick();
    do_cycle(4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 4'h9, 1'b1, -1, 12'h000);
    for (int c = 10; c < 16; c++) begin
      e_dir = (c == 12 || c == 13);
      e_out = e_dir ? 4'h9 : 4'h0;
      checks++; if (c_dir[c] !== e_dir || c_out[c] !== e_out || c_rv[c] !== 1'b0) begin errors++; $display("FAIL x2_write c%0d: dir=%b out=%h rv=%b expected %b/%h/0", c, c_dir[c], c_out[c], c_rv[c], e_dir, e_out); end
    end
    do_cycle(4'h1, 4'h2, 4'h6, 1'b0, 1'b1, 4'h0, 1'b1, -1, 12'h000);
    checks++; if (c_ph[0] !== 3'd0 || c_dir[0] !== 1'b1) begin errors++; $display("FAIL x2_b2b: phase=%0d dir=%b expected 0/1", c_ph[0], c_dir[0]); end
    for (int c = 10; c < 16; c++) begin
      checks++; if (c_dir[c] !== 1'b0 || c_out[c] !== 4'h0 || c_rv[c] !== (c == 14)) begin errors++; $display("FAIL x2_read c%0d: dir=%b out=%h rv=%b expected 0/0/%b", c, c_dir[c], c_out[c], c_rv[c], (c == 14)); end
    end
    checks++; if (rd_data !== 4'h6) begin errors++; $display("FAIL x2_rdata: rd_data=%h expected 6", rd_data); end
    do_cycle(4'h1, 4'h2, 4'hF, 1'b1, 1'b1, 4'h3, 1'b0, 0, 12'h000);
    for (int c = 10; c < 16; c++) begin
      e_dir = (c == 12 || c == 13);
      e_out = e_dir ? 4'h3 : 4'h0;
      checks++; if (c_dir[c] !== e_dir || c_out[c] !== e_out || c_rv[c] !== 1'b0) begin errors++; $display("FAIL x2_both c%0d: dir=%b out=%h rv=%b expected %b/%h/0", c, c_dir[c], c_out[c], c_rv[c], e_dir, e_out); end
    end
    checks++; if (rd_data !== 4'h6) begin errors++; $display("FAIL x2_hold: rd_data=%h expected 6", rd_data); end
  endtask

  task automatic test_back_to_back;
    addr_in = 12'h5A3; cm_sel = 2'd3; run = 1'b1;
    tick();
    do_cycle(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, -1, 12'h1C7);
    checks++; if (c_out[2] !== 4'hA || c_out[4] !== 4'h5) begin errors++; $display("FAIL b2b_latched: A2=%h A3=%h expected A/5", c_out[2], c_out[4]); end
    do_cycle(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8, 12'h1C7);
    for (int c = 0; c < 6; c++) begin
      e_out = (c < 2) ? 4'h7 : (c < 4) ? 4'hC : 4'h1;
      checks++; if (c_out[c] !== e_out || c_ph[c] !== 3'(c / 2)) begin errors++; $display("FAIL b2b_addr c%0d: out=%h ph=%0d expected %h/%0d", c, c_out[c], c_ph[c], e_out, c / 2); end
    end
    checks++; if (c_sync[14] !== 1'b1 || c_sync[15] !== 1'b1) begin errors++; $display("FAIL b2b_finish: sync=%b%b expected 11", c_sync[14], c_sync[15]); end
    tick(); tick();
    checks++; if (phase !== 3'd0 || data_dir !== 1'b0 || cmrom !== 1'b0 || cmram !== 4'h0 || sync_out !== 1'b0) begin errors++; $display("FAIL b2b_idle: ph=%0d dir=%b rom=%b ram=%b sync=%b expected 0", phase, data_dir, cmrom, cmram, sync_out); end
  endtask

  task automatic test_reset_mid;
    addr_in = 12'h5A3; cm_sel = 2'd2; run = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      data_in = (c == 6 || c == 7) ? 4'hD : 4'h0;
      x2_wr   = (c >= 10);
      x_wdata = 4'h9;
      tick();
    end
    x2_wr = 1'b0; data_in = '0;
    checks++; if (data_dir !== 1'b1 || data_out !== 4'h9 || opr !== 4'hD) begin errors++; $display("FAIL rst_pre: dir=%b out=%h opr=%h expected 1/9/D", data_dir, data_out, opr); end
    #2 poc_n = 1'b0;
    #1;
    checks++; if (data_dir !== 1'b0 || data_out !== 4'h0 || cmrom !== 1'b0 || cmram !== 4'h0 || sync_out !== 1'b0) begin errors++; $display("FAIL rst_async: dir=%b out=%h rom=%b ram=%b sync=%b expected 0", data_dir, data_out, cmrom, cmram, sync_out); end
    checks++; if (opr !== 4'h0 || rd_data !== 4'h0 || phase !== 3'd0) begin errors++; $display("FAIL rst_latch: opr=%h rd=%h ph=%0d expected 0", opr, rd_data, phase); end
    @(negedge sysclk) poc_n = 1'b1;
    tick();
    checks++; if (phase !== 3'd0 || data_dir !== 1'b1 || data_out !== 4'h3) begin errors++; $display("FAIL rst_restart: ph=%0d dir=%b out=%h expected 0/1/3", phase, data_dir, data_out); end
    do_cycle(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 12'h5A3);
    checks++; if (c_dir[12] !== 1'b0 || c_out[12] !== 4'h0) begin errors++; $display("FAIL rst_discard: dir=%b out=%h expected 0/0", c_dir[12], c_out[12]); end
  endtask

  task automatic test_param;
    logic [3:0] nibs[4];
    nibs = '{4'h4, 4'hC, 4'h2, 4'hB};
    addr_in2 = 16'hB2C4; cm_sel2 = 3'd5; run2 = 1'b1;
    tick();
    for (int c = 0; c < 27; c++) begin
      if (c == 0) run2 = 1'b0;
      e_dir = (c < 12);
      e_out = e_dir ? nibs[c / 3] : 4'h0;
      e_rom = (c >= 9 && c < 12);
      checks++; if (data_dir2 !== e_dir || data_out2 !== e_out) begin errors++; $display("FAIL p_bus c%0d: dir=%b out=%h expected %b/%h", c, data_dir2, data_out2, e_dir, e_out); end
      checks++; if (cmrom2 !== e_rom || cmram2 !== (e_rom ? 8'b0010_0000 : 8'h00)) begin errors++; $display("FAIL p_cm c%0d: rom=%b ram=%b expected %b", c, cmrom2, cmram2, e_rom); end
      checks++; if (sync_out2 !== (c >= 24) || instr_valid2 !== (c == 18)) begin errors++; $display("FAIL p_ctl c%0d: sync=%b iv=%b expected %b/%b", c, sync_out2, instr_valid2, (c >= 24), (c == 18)); end
      checks++; if (phase2 !== 4'(c / 3)) begin errors++; $display("FAIL p_phase c%0d: phase=%0d expected %0d", c, phase2, c / 3); end
      tick();
    end
    checks++; if (phase2 !== 4'd0 || data_dir2 !== 1'b0 || sync_out2 !== 1'b0) begin errors++; $display("FAIL p_idle: ph=%0d dir=%b sync=%b expected 0", phase2, data_dir2, sync_out2); end
  endtask

  initial begin
    test_reset();
    test_addr_phase();
    test_io_opr();
    test_x2();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcs4_bus_sequencer.md
Name: mcs4_bus_sequencer

Overview:
- Parametrised successor to the fixed 4004 bus phase logic; owns the multiplexed CPU data bus and its CM/SYNC strobes.
- Steps an instruction cycle of ADDR_NIBBLES address phases, then M1, M2, X1, X2, X3. Each phase lasts PHASE_CLKS sysclk cycles.
- Drives address nibbles, captures OPR/OPA, decodes the I/O opcode for M2 CM strobes, and performs one optional X2 write or read per cycle.
- Split in/out/dir data bus, no tri-states; sits between the decode/ALU core and the pads.

Parameters:
DATA_W, 4, bus width in bits
ADDR_NIBBLES, 3, number of address phases (>=1)
N_CMRAM, 4, number of CMRAM strobe lines (>=1)
PHASE_CLKS, 2, sysclk cycles per phase (>=2)
IO_OPR, 4'hE, OPR value that marks an I/O instruction (DATA_W bits)

Ports:
sysclk  in  1  system clock
poc_n  in  1  asynchronous active-low reset
run  in  1  start or continue instruction cycles
addr_in  in  DATA_W*ADDR_NIBBLES  fetch address, sampled on A1 entry
cm_sel  in  clog2(N_CMRAM)  CMRAM bank select, sampled on A1 entry
data_in  in  DATA_W  bus input from pads
data_out  out  DATA_W  bus output value
data_dir  out  1  1 = drive data_out onto the bus
x2_wr  in  1  request bus write during X2
x2_rd  in  1  request bus read during X2
x_wdata  in  DATA_W  X2 write data
opr  out  DATA_W  latched OPR
opa  out  DATA_W  latched OPA
instr_valid  out  1  one-clock pulse: opr/opa valid
rd_data  out  DATA_W  X2 read capture
rd_valid  out  1  one-clock pulse: rd_data valid
cmrom  out  1  ROM command strobe
cmram  out  N_CMRAM  RAM command strobes
sync_out  out  1  SYNC, high throughout X3
phase  out  clog2(ADDR_NIBBLES+5)  current phase index, A1=0 .. X3=ADDR_NIBBLES+4

Behaviour:
- Reset (poc_n low, async): state IDLE, phase=0, sub-counter=0. All outputs 0, including opr/opa/rd_data.
- IDLE: all strobes and data_dir are 0.
  - run=1 sampled in IDLE -> next clock enters A1 with sub=0.
  - Entering A1 latches addr_in and cm_sel.
- Phase timing: sub counts 0..PHASE_CLKS-1. When sub reaches PHASE_CLKS-1, phase advances and sub resets to 0.
- End of X3: if run=1, go straight to A1 with no gap and relatch addr/cm_sel; otherwise go to IDLE. run has no effect mid-cycle.
- Address phase Ak (k=1..ADDR_NIBBLES): data_dir=1, data_out = address nibble k-1, least significant first.
- Last address phase:
  - cmrom=1.
  - cmram[cm_sel]=1.
  - All other cmram bits are 0.
- M1: data_in sampled on the last clock (sub=PHASE_CLKS-1) -> opr.
- M2: data_in sampled on the last clock -> opa.
  - If latched opr==IO_OPR, cmrom and cmram[cm_sel] are high for all of M2.
- X1:
  - instr_valid=1 on the first clock (sub=0).
  - x2_wr, x2_rd, x_wdata are sampled on the last clock of X1.
- X2, write latched: data_dir=1 and data_out=x_wdata for all of X2.
- X2, read latched (and no write): data_in sampled on the last clock of X2 -> rd_data; rd_valid=1 on the next clock (X3, sub=0).
- x2_wr and x2_rd both high: the write wins; no read and no rd_valid.
- X3: sync_out=1 for the whole phase.
- data_dir=0 in M1, M2, X1, X3, and in X2 with no write. data_out is 0 whenever data_dir=0.
- Latency: instr_valid comes (ADDR_NIBBLES+2)*PHASE_CLKS clocks after A1 entry. Cycle length = (ADDR_NIBBLES+5)*PHASE_CLKS clocks.
- opr, opa, rd_data hold their values until overwritten.
- Reset mid-cycle: immediate return to IDLE with all outputs 0. The pending X2 request and the latched address are discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Defaults; run=1, addr_in=12'h5A3, cm_sel=2 → A1/A2/A3 drive 3, A, 5 for 2 clocks each with data_dir=1. cmrom=1 and cmram=4'b0100 during A3 only. sync_out high on clocks 14-15 of the 16-clock cycle.
- data_in=4'hD in M1, 4'h4 in M2 → opr=D, opa=4, instr_valid pulses on the first X1 clock (clock 10 after A1 entry). No M2 CM strobes.
- data_in=E in M1 (IO_OPR), cm_sel=1 → cmrom=1 and cmram=4'b0010 during both A3 and M2.
- x2_wr=1, x_wdata=9 at X1 end → data_dir=1, data_out=9 for both X2 clocks. Repeat with x2_rd=1 and data_in=6 in X2 → rd_data=6 and rd_valid pulses on the first X3 clock. Both requests high → write only, no rd_valid.
- run drops mid-M2 → cycle completes through X3, then IDLE with all strobes 0. run stays high → back-to-back cycles with no idle clock and new addr_in latched.
- poc_n low during X2 write → data_dir, data_out, cmrom, cmram, sync_out go to 0 asynchronously. After release with run=1, the sequence restarts at A1.
- ADDR_NIBBLES=4, PHASE_CLKS=3, N_CMRAM=8 → 27-clock cycle, 4 address phases, cmram bit cm_sel set during A4.
